// File: rtl/frame_buffer_ctrl.sv
// rtl/frame_buffer_ctrl.sv - frame buffer write sequencer (capture/clear) and VGA read address mapper
// Optional clear engine and capture-after-clear chaining enabled by defining FB_CTRL_CLEAR_EN.
module frame_buffer_ctrl #(
  parameter int c_img_cols    = 320,
  parameter int c_img_rows    = 240,
  parameter int c_img_pxls    = c_img_cols * c_img_rows,
  parameter int c_nb_img_pxls = 17,
  parameter int c_nb_vga      = 10,
  parameter int c_nb_buf      = 12
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cam_vsync,
  input  logic                     cam_pxl_vld,
  input  logic [15:0]              cam_pxl,
  input  logic                     capture_start,
  input  logic                     capture_cont,
  input  logic                     clear_start,
  input  logic [c_nb_buf-1:0]      clear_color,
  input  logic [c_nb_vga-1:0]      vga_col,
  input  logic [c_nb_vga-1:0]      vga_row,
  output logic                     fb_wea,
  output logic [c_nb_img_pxls-1:0] fb_addra,
  output logic [c_nb_buf-1:0]      fb_dina,
  output logic [c_nb_img_pxls-1:0] fb_addrb,
  output logic                     pxl_in_img,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     err_ovf
);

  localparam logic [c_nb_img_pxls-1:0] LP_PXLS  = c_nb_img_pxls'(c_img_pxls);
  localparam logic [c_nb_img_pxls-1:0] LP_LAST  = c_nb_img_pxls'(c_img_pxls - 1);
  localparam logic [c_nb_img_pxls-1:0] LP_ONE   = c_nb_img_pxls'(1);
  localparam logic [c_nb_img_pxls-1:0] LP_COLS  = c_nb_img_pxls'(c_img_cols);
  localparam logic [c_nb_vga-1:0]      LP_COL_V = c_nb_vga'(c_img_cols);
  localparam logic [c_nb_vga-1:0]      LP_ROW_V = c_nb_vga'(c_img_rows);

`ifdef FB_CTRL_CLEAR_EN
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;
`endif

  state_t                     r_state, w_next_state;
  logic [c_nb_img_pxls-1:0]   r_cnt, w_cnt;
  logic                       r_vsync_q;
  logic                       r_capture_pend, w_capture_pend;
  logic                       r_err_ovf, w_err_ovf;
  logic                       r_wea, w_wea;
  logic [c_nb_img_pxls-1:0]   r_addra, w_addra;
  logic [c_nb_buf-1:0]        r_dina, w_dina;
  logic                       r_frame_done, w_frame_done;
  logic                       r_busy;
  logic [c_nb_img_pxls-1:0]   r_addrb;
  logic                       r_in_img_q1, r_in_img_q2;
  logic                       w_vs_rise;
  logic                       w_in_img;
  logic [c_nb_img_pxls-1:0]   w_rd_addr;

  assign w_vs_rise = cam_vsync & ~r_vsync_q;

`ifndef FB_CTRL_CLEAR_EN
  logic w_unused_clear;
  assign w_unused_clear = ^{clear_start, clear_color};
`endif

  always_comb begin
    w_next_state   = r_state;
    w_cnt          = r_cnt;
    w_capture_pend = r_capture_pend;
    w_err_ovf      = r_err_ovf;
    w_wea          = 1'b0;
    w_addra        = r_addra;
    w_dina         = r_dina;
    w_frame_done   = 1'b0;
    case (r_state)
      IDLE: begin
`ifdef FB_CTRL_CLEAR_EN
        if (clear_start) begin
          w_next_state   = CLEAR;
          w_cnt          = '0;
          w_capture_pend = capture_start;
          if (capture_start) w_err_ovf = 1'b0;
        end else
`endif
        if (capture_start) begin
          w_next_state = ARMED;
          w_err_ovf    = 1'b0;
        end
      end
      ARMED: begin
        if (w_vs_rise) begin
          w_next_state = CAPTURE;
          w_cnt        = '0;
        end
      end
      CAPTURE: begin
        // A frame boundary wins over a pixel arriving in the same cycle.
        if (w_vs_rise) begin
          w_frame_done = 1'b1;
          w_cnt        = '0;
          if (!capture_cont) w_next_state = IDLE;
        end else if (cam_pxl_vld) begin
          if (r_cnt < LP_PXLS) begin
            w_wea   = 1'b1;
            w_addra = r_cnt;
            w_dina  = {cam_pxl[15:12], cam_pxl[10:7], cam_pxl[4:1]};
            w_cnt   = r_cnt + LP_ONE;
          end else begin
            w_err_ovf = 1'b1;
          end
        end
      end
`ifdef FB_CTRL_CLEAR_EN
      CLEAR: begin
        w_wea   = 1'b1;
        w_addra = r_cnt;
        w_dina  = clear_color;
        w_cnt   = r_cnt + LP_ONE;
        if (r_cnt == LP_LAST) begin
          w_cnt          = '0;
          w_next_state   = r_capture_pend ? ARMED : IDLE;
          w_capture_pend = 1'b0;
        end
      end
`endif
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_vsync_q      <= 1'b0;
      r_capture_pend <= 1'b0;
      r_err_ovf      <= 1'b0;
      r_wea          <= 1'b0;
      r_addra        <= '0;
      r_dina         <= '0;
      r_frame_done   <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_cnt          <= w_cnt;
      r_vsync_q      <= cam_vsync;
      r_capture_pend <= w_capture_pend;
      r_err_ovf      <= w_err_ovf;
      r_wea          <= w_wea;
      r_addra        <= w_addra;
      r_dina         <= w_dina;
      r_frame_done   <= w_frame_done;
      r_busy         <= (w_next_state != IDLE);
    end
  end

  // Read address lands one cycle after the coordinates; the flag trails by two to match doutb.
  assign w_in_img  = (vga_col < LP_COL_V) && (vga_row < LP_ROW_V);
  assign w_rd_addr = c_nb_img_pxls'(vga_row) * LP_COLS + c_nb_img_pxls'(vga_col);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_addrb     <= '0;
      r_in_img_q1 <= 1'b0;
      r_in_img_q2 <= 1'b0;
    end else begin
      r_addrb     <= w_in_img ? w_rd_addr : '0;
      r_in_img_q1 <= w_in_img;
      r_in_img_q2 <= r_in_img_q1;
    end
  end

  assign fb_wea     = r_wea;
  assign fb_addra   = r_addra;
  assign fb_dina    = r_dina;
  assign fb_addrb   = r_addrb;
  assign pxl_in_img = r_in_img_q2;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign err_ovf    = r_err_ovf;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// tb/tb_frame_buffer_ctrl.sv - directed self-checking bench for frame_buffer_ctrl
// Image is 320x3 so full frames and clears stay short while keeping the 320-column address map.
module tb_frame_buffer_ctrl;

  localparam int COLS = 320;
  localparam int ROWS = 3;
  localparam int PXLS = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cam_vsync;
  logic        cam_pxl_vld;
  logic [15:0] cam_pxl;
  logic        capture_start;
  logic        capture_cont;
  logic        clear_start;
  logic [11:0] clear_color;
  logic [9:0]  vga_col;
  logic [9:0]  vga_row;
  logic        fb_wea;
  logic [16:0] fb_addra;
  logic [11:0] fb_dina;
  logic [16:0] fb_addrb;
  logic        pxl_in_img;
  logic        busy;
  logic        frame_done;
  logic        err_ovf;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  frame_buffer_ctrl #(
    .c_img_cols(COLS),
    .c_img_rows(ROWS)
  ) dut (
    .clk(clk), .rstn(rstn), .cam_vsync(cam_vsync), .cam_pxl_vld(cam_pxl_vld),
    .cam_pxl(cam_pxl), .capture_start(capture_start), .capture_cont(capture_cont),
    .clear_start(clear_start), .clear_color(clear_color), .vga_col(vga_col),
    .vga_row(vga_row), .fb_wea(fb_wea), .fb_addra(fb_addra), .fb_dina(fb_dina),
    .fb_addrb(fb_addrb), .pxl_in_img(pxl_in_img), .busy(busy),
    .frame_done(frame_done), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (frame_done) done_cnt++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic vsync_rise();
    cam_vsync = 1'b1; tick();
    cam_vsync = 1'b0; tick();
  endtask

  initial begin
    int bad;
    int nwr;
    int last;
    int d0;
    rstn = 1'b0; cam_vsync = 1'b0; cam_pxl_vld = 1'b0; cam_pxl = 16'h0;
    capture_start = 1'b0; capture_cont = 1'b0; clear_start = 1'b0;
    clear_color = 12'h0; vga_col = 10'd0; vga_row = 10'd0;
    tick(); tick();
    check("rst_wea", 32'(fb_wea), 32'd0);
    check("rst_addra", 32'(fb_addra), 32'd0);
    check("rst_dina", 32'(fb_dina), 32'd0);
    check("rst_addrb", 32'(fb_addrb), 32'd0);
    check("rst_in_img", 32'(pxl_in_img), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_ovf", 32'(err_ovf), 32'd0);
    rstn = 1'b1; tick();

    // single full frame
    capture_start = 1'b1; tick(); capture_start = 1'b0;
    check("armed_busy", 32'(busy), 32'd1);
    cam_pxl_vld = 1'b1; cam_pxl = 16'hF81F; tick(); cam_pxl_vld = 1'b0;
    check("armed_no_write", 32'(fb_wea), 32'd0);
    vsync_rise();
    bad = 0;
    for (int i = 0; i < PXLS; i++) begin
      cam_pxl_vld = 1'b1; cam_pxl = 16'hF81F; tick();
      if (!(fb_wea === 1'b1 && fb_addra === 17'(i) && fb_dina === 12'hF0F)) bad++;
      cam_pxl_vld = 1'b0; tick();
      if (fb_wea !== 1'b0) bad++;
    end
    check("frame_writes", 32'(bad), 32'd0);
    check("frame_no_ovf", 32'(err_ovf), 32'd0);
    cam_vsync = 1'b1; tick();
    check("frame_done_pulse", 32'(frame_done), 32'd1);
    check("frame_idle", 32'(busy), 32'd0);
    cam_vsync = 1'b0; tick();
    check("frame_done_1cyc", 32'(frame_done), 32'd0);

    // continuous capture, three short frames
    capture_cont = 1'b1; capture_start = 1'b1; tick(); capture_start = 1'b0;
    vsync_rise();
    d0 = done_cnt; bad = 0;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 10; i++) begin
        cam_pxl_vld = 1'b1; cam_pxl = 16'h1234; tick();
        if (!(fb_wea === 1'b1 && fb_addra === 17'(i) && fb_dina === 12'h14A)) bad++;
      end
      cam_pxl_vld = 1'b0;
      vsync_rise();
    end
    check("cont_addr_restart", 32'(bad), 32'd0);
    check("cont_done_count", 32'(done_cnt - d0), 32'd3);
    check("cont_stays_busy", 32'(busy), 32'd1);
    capture_cont = 1'b0; cam_vsync = 1'b1; tick();
    check("cont_end_done", 32'(frame_done), 32'd1);
    check("cont_end_idle", 32'(busy), 32'd0);
    cam_vsync = 1'b0; tick();

    // oversize frame
    capture_start = 1'b1; tick(); capture_start = 1'b0;
    vsync_rise();
    nwr = 0; last = -1;
    for (int i = 0; i < PXLS + 5; i++) begin
      cam_pxl_vld = 1'b1; cam_pxl = 16'hF81F; tick();
      if (fb_wea) begin nwr++; last = int'(fb_addra); end
      if (i == PXLS - 1) check("ovf_not_yet", 32'(err_ovf), 32'd0);
      if (i == PXLS) check("ovf_set", 32'(err_ovf), 32'd1);
    end
    cam_pxl_vld = 1'b0;
    check("ovf_write_count", 32'(nwr), 32'(PXLS));
    check("ovf_last_addr", 32'(last), 32'(PXLS - 1));
    cam_vsync = 1'b1; tick(); cam_vsync = 1'b0;
    check("ovf_sticky_done", 32'(frame_done), 32'd1);
    check("ovf_sticky", 32'(err_ovf), 32'd1);
    tick();
    capture_start = 1'b1; tick(); capture_start = 1'b0;
    check("ovf_cleared", 32'(err_ovf), 32'd0);
    vsync_rise(); vsync_rise();
    check("ovf_back_idle", 32'(busy), 32'd0);

`ifdef FB_CTRL_CLEAR_EN
    // clear alone, camera activity ignored
    clear_color = 12'hABC; clear_start = 1'b1; tick(); clear_start = 1'b0;
    check("clr_busy", 32'(busy), 32'd1);
    bad = 0; nwr = 0;
    for (int k = 0; k < 2000; k++) begin
      cam_pxl_vld = 1'b1; cam_pxl = 16'hF81F; cam_vsync = k[0];
      tick();
      if (fb_wea) begin
        if (!(fb_addra === 17'(nwr) && fb_dina === 12'hABC)) bad++;
        nwr++;
      end else if (nwr > 0) break;
    end
    cam_pxl_vld = 1'b0; cam_vsync = 1'b0; tick();
    check("clr_count", 32'(nwr), 32'(PXLS));
    check("clr_data", 32'(bad), 32'd0);
    check("clr_idle", 32'(busy), 32'd0);

    // clear and capture together: clear first, then armed
    cam_vsync = 1'b1;
    clear_start = 1'b1; capture_start = 1'b1; tick();
    clear_start = 1'b0; capture_start = 1'b0;
    bad = 0; nwr = 0;
    for (int k = 0; k < 2000; k++) begin
      cam_pxl_vld = 1'b1; cam_pxl = 16'hF81F;
      tick();
      if (fb_wea) begin
        if (!(fb_addra === 17'(nwr) && fb_dina === 12'hABC)) bad++;
        nwr++;
      end else if (nwr > 0) break;
    end
    check("clrcap_count", 32'(nwr), 32'(PXLS));
    check("clrcap_no_cam", 32'(bad), 32'd0);
    check("clrcap_armed", 32'(busy), 32'd1);
    tick(); tick();
    check("clrcap_armed_nowr", 32'(fb_wea), 32'd0);
    cam_pxl_vld = 1'b0; cam_vsync = 1'b0; tick();
    cam_vsync = 1'b1; tick();
    cam_vsync = 1'b0; cam_pxl_vld = 1'b1; cam_pxl = 16'h1234; tick(); cam_pxl_vld = 1'b0;
    check("clrcap_first_wr", 32'({fb_wea, fb_addra, fb_dina}), 32'({1'b1, 17'd0, 12'h14A}));
    vsync_rise();
    check("clrcap_idle", 32'(busy), 32'd0);
`else
    clear_color = 12'hABC; clear_start = 1'b1; tick(); clear_start = 1'b0;
    check("noclr_idle", 32'(busy), 32'd0);
    check("noclr_nowr", 32'(fb_wea), 32'd0);
    clear_start = 1'b1; capture_start = 1'b1; tick();
    clear_start = 1'b0; capture_start = 1'b0;
    check("noclr_armed", 32'(busy), 32'd1);
    cam_vsync = 1'b1; tick();
    cam_vsync = 1'b0; cam_pxl_vld = 1'b1; cam_pxl = 16'h1234; tick(); cam_pxl_vld = 1'b0;
    check("noclr_first_wr", 32'({fb_wea, fb_addra, fb_dina}), 32'({1'b1, 17'd0, 12'h14A}));
    vsync_rise();
    check("noclr_back_idle", 32'(busy), 32'd0);
`endif

    // read side pipeline
    vga_col = 10'd5; vga_row = 10'd2; tick();
    check("rd_addr_645", 32'(fb_addrb), 32'd645);
    vga_col = 10'd320; vga_row = 10'd0; tick();
    check("rd_in_img_645", 32'(pxl_in_img), 32'd1);
    check("rd_addr_col320", 32'(fb_addrb), 32'd0);
    vga_col = 10'd319; vga_row = 10'd2; tick();
    check("rd_in_col320", 32'(pxl_in_img), 32'd0);
    check("rd_addr_959", 32'(fb_addrb), 32'd959);
    vga_col = 10'd0; vga_row = 10'd3; tick();
    check("rd_in_959", 32'(pxl_in_img), 32'd1);
    check("rd_addr_row3", 32'(fb_addrb), 32'd0);
    vga_col = 10'd0; vga_row = 10'd0; tick();
    check("rd_in_row3", 32'(pxl_in_img), 32'd0);
    check("rd_addr_origin", 32'(fb_addrb), 32'd0);
    vga_col = 10'd5; vga_row = 10'd2; tick();
    check("rd_in_origin", 32'(pxl_in_img), 32'd1);

    // reset in the middle of a capture
    capture_start = 1'b1; tick(); capture_start = 1'b0;
    vsync_rise();
    for (int i = 0; i < 4; i++) begin
      cam_pxl_vld = 1'b1; cam_pxl = 16'hF81F; tick();
    end
    check("mid_pre_addra", 32'(fb_addra), 32'd3);
    rstn = 1'b0; tick();
    check("mid_rst_wea", 32'(fb_wea), 32'd0);
    check("mid_rst_addra", 32'(fb_addra), 32'd0);
    check("mid_rst_dina", 32'(fb_dina), 32'd0);
    check("mid_rst_addrb", 32'(fb_addrb), 32'd0);
    check("mid_rst_in_img", 32'(pxl_in_img), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(frame_done), 32'd0);
    check("mid_rst_ovf", 32'(err_ovf), 32'd0);
    cam_pxl_vld = 1'b0; rstn = 1'b1; tick();
    cam_pxl_vld = 1'b1; tick(); cam_pxl_vld = 1'b0;
    check("post_rst_idle_nowr", 32'(fb_wea), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
